halfband_decim2: RTL

HALFBAND_DECIM2 -- requirements
Module: halfband_decim2

---
 rtl/halfband_decim2_if.sv | 27 ++
 rtl/halfband_decim2.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/halfband_decim2_if.sv
// Sample-in / decimated-sample-out bundle for the halfband decimator.
// master drives the input strobe and sample; slave is the decimator side.
interface halfband_decim2_if #(
    parameter int WIDTH = 18
);
    logic                    sam_clk_en;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] y;
    logic                    y_valid;
    logic                    overrun;

    modport master (
        output sam_clk_en,
        output x_in,
        input  y,
        input  y_valid,
        input  overrun
    );

    modport slave (
        input  sam_clk_en,
        input  x_in,
        output y,
        output y_valid,
        output overrun
    );
endinterface

// File: rtl/halfband_decim2.sv
// 15-tap halfband FIR decimator by 2.
// The input samples shift into a delay line held as 2s16 (input halved).
// Every second accepted sample triggers a computation that folds the
// symmetric taps into four pre-added pairs, seeds the accumulator with the
// centre tap (coefficient 0.5, a pure shift), then runs four MAC cycles on a
// single shared 18x18 multiplier. The result is floored and saturated to 1s17.
module halfband_decim2 #(
    parameter int WIDTH  = 18,
    parameter int LENGTH = 15
) (
    input  logic             sys_clk,
    input  logic             reset,
    halfband_decim2_if.slave bus
);

    localparam int ACC_W  = 40;
    localparam int COEF_W = 18;
    localparam int PROD_W = WIDTH + COEF_W;
    localparam int NPAIR  = 4;
    localparam int CENTER = (LENGTH - 1) / 2;
    localparam int FRAC   = 17;

    // Non-zero outer coefficients, 0s18.
    localparam logic signed [COEF_W-1:0] H0 = -18'sd348;
    localparam logic signed [COEF_W-1:0] H2 =  18'sd3274;
    localparam logic signed [COEF_W-1:0] H4 = -18'sd15925;
    localparam logic signed [COEF_W-1:0] H6 =  18'sd78535;

    // Output saturation limits, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] Y_MIN = -Y_MAX - ACC_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        MAC,
        DONE
    } state_t;

    state_t state;

    logic signed [WIDTH-1:0]  line [LENGTH];
    logic                     phase;
    logic                     trigger;

    logic signed [WIDTH-1:0]  s [NPAIR];
    logic        [1:0]        cnt;
    logic signed [ACC_W-1:0]  acc;

    logic signed [WIDTH-1:0]  s_sel;
    logic signed [COEF_W-1:0] coef_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_scaled;
    logic signed [WIDTH-1:0]  y_sat;

    logic signed [WIDTH-1:0]  y_r;
    logic                     y_valid_r;
    logic                     overrun_r;

    assign trigger = bus.sam_clk_en & phase;

    // Delay line and decimation phase: every accepted sample shifts in,
    // regardless of what the computation FSM is doing.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < LENGTH; i++) begin
                line[i] <= '0;
            end
            phase <= 1'b0;
        end else if (bus.sam_clk_en) begin
            line[0] <= {bus.x_in[WIDTH-1], bus.x_in[WIDTH-1:1]};
            for (int unsigned i = 1; i < LENGTH; i++) begin
                line[i] <= line[i-1];
            end
            phase <= ~phase;
        end
    end

    // Shared multiplier operands: pair and coefficient chosen by MAC step.
    always_comb begin
        s_sel    = s[cnt];
        coef_sel = '0;
        case (cnt)
            2'd0:    coef_sel = H0;
            2'd1:    coef_sel = H2;
            2'd2:    coef_sel = H4;
            default: coef_sel = H6;
        endcase
        prod = PROD_W'(s_sel) * PROD_W'(coef_sel);
    end

    // Floor by arithmetic shift, then clamp to the signed output range.
    always_comb begin
        acc_scaled = acc >>> FRAC;
        y_sat      = acc_scaled[WIDTH-1:0];
        if (acc_scaled > Y_MAX) begin
            y_sat = Y_MAX[WIDTH-1:0];
        end else if (acc_scaled < Y_MIN) begin
            y_sat = Y_MIN[WIDTH-1:0];
        end
    end

    // Computation FSM: snapshot, four MAC steps, registered result.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state     <= IDLE;
            for (int unsigned k = 0; k < NPAIR; k++) begin
                s[k] <= '0;
            end
            cnt       <= '0;
            acc       <= '0;
            y_r       <= '0;
            y_valid_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            y_valid_r <= 1'b0;
            overrun_r <= trigger && (state != IDLE);
            case (state)
                IDLE: begin
                    if (trigger) begin
                        state <= PRE;
                    end
                end
                PRE: begin
                    // Symmetric taps are pre-added so each MAC step covers two taps.
                    for (int unsigned k = 0; k < NPAIR; k++) begin
                        s[k] <= line[2*k] + line[LENGTH-1-2*k];
                    end
                    acc   <= ACC_W'(line[CENTER]) <<< FRAC;
                    cnt   <= '0;
                    state <= MAC;
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    y_r       <= y_sat;
                    y_valid_r <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.y       = y_r;
    assign bus.y_valid = y_valid_r;
    assign bus.overrun = overrun_r;

endmodule
